// File: rtl/gshare_pht_if.sv
// Commit-to-updater and updater-to-PHT signal bundle for the gshare PHT updater.
// master drives commit results and write-port readiness; slave is the updater.
interface gshare_pht_if #(
  parameter int PC_W    = 32,
  parameter int BHR_LEN = 8,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               cm_valid_i;
  logic               cm_ready_o;
  logic [PC_W-1:0]    cm_pc_i;
  logic [BHR_LEN-1:0] cm_bhr_i;
  logic [1:0]         cm_pht_i;
  logic               cm_taken_i;
  logic               cm_mispredict_i;
  logic               wr_ready_i;
  logic               wepht_o;
  logic [1:0]         fixpht_o;
  logic [PC_W-1:0]    fixpc_o;
  logic [BHR_LEN-1:0] fixbhr_o;
  logic               prmiss_o;
  logic [BHR_LEN-1:0] prmiss_bhr_o;
  logic               prmiss_taken_o;
  logic [CW-1:0]      count_o;

  modport master (
    output cm_valid_i, cm_pc_i, cm_bhr_i, cm_pht_i, cm_taken_i, cm_mispredict_i, wr_ready_i,
    input  cm_ready_o, wepht_o, fixpht_o, fixpc_o, fixbhr_o,
           prmiss_o, prmiss_bhr_o, prmiss_taken_o, count_o
  );

  modport slave (
    input  cm_valid_i, cm_pc_i, cm_bhr_i, cm_pht_i, cm_taken_i, cm_mispredict_i, wr_ready_i,
    output cm_ready_o, wepht_o, fixpht_o, fixpc_o, fixbhr_o,
           prmiss_o, prmiss_bhr_o, prmiss_taken_o, count_o
  );
endinterface

// File: rtl/gshare_pht_updater.sv
// Commit-side gshare PHT updater: steps 2-bit counters, coalesces pending writes
// per PHT index in a small FIFO, drains them to the PHT, and pulses BHR repair.
module gshare_pht_updater #(
  parameter int PC_W    = 32,
  parameter int BHR_LEN = 8,
  parameter int DEPTH   = 4
) (
  input logic        clk,
  input logic        rst,
  gshare_pht_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [1:0] step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else       return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [1:0]         ctr_q [DEPTH];
  logic [1:0]         ctr_d [DEPTH];
  logic [PC_W-1:0]    pc_q  [DEPTH];
  logic [PC_W-1:0]    pc_d  [DEPTH];
  logic [BHR_LEN-1:0] bhr_q [DEPTH];
  logic [BHR_LEN-1:0] bhr_d [DEPTH];
  logic [BHR_LEN-1:0] idx_q [DEPTH];
  logic [BHR_LEN-1:0] idx_d [DEPTH];
  logic [CW-1:0]      head_q, head_d, tail_q, tail_d;
  logic               prmiss_q, prmiss_d, prmiss_taken_q, prmiss_taken_d;
  logic [BHR_LEN-1:0] prmiss_bhr_q, prmiss_bhr_d;

  logic [CW-1:0]      count;
  logic [AW-1:0]      head_ptr, tail_ptr, hit_slot;
  logic [BHR_LEN-1:0] in_idx;
  logic [DEPTH-1:0]   match;
  logic               full, empty, drain, head_hit, nonhead_hit, accept;

  assign count       = tail_q - head_q;
  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign head_ptr    = head_q[AW-1:0];
  assign tail_ptr    = tail_q[AW-1:0];
  assign in_idx      = bus.cm_pc_i[2 +: BHR_LEN] ^ bus.cm_bhr_i;
  assign drain       = !empty && bus.wr_ready_i;
  assign head_hit    = match[head_ptr];
  assign nonhead_hit = (|match) && !head_hit;
  assign accept      = bus.cm_valid_i && bus.cm_ready_o;

  // At most one valid entry shares an index, so the OR-reduced slot is exact.
  always_comb begin
    match    = '0;
    hit_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (idx_q[i] == in_idx)) begin
        match[i] = 1'b1;
        hit_slot = AW'(i);
      end
    end
  end

  always_comb begin
    valid_d        = valid_q;
    ctr_d          = ctr_q;
    pc_d           = pc_q;
    bhr_d          = bhr_q;
    idx_d          = idx_q;
    head_d         = head_q;
    tail_d         = tail_q;
    prmiss_d       = 1'b0;
    prmiss_bhr_d   = prmiss_bhr_q;
    prmiss_taken_d = prmiss_taken_q;
    if (drain) begin
      valid_d[head_ptr] = 1'b0;
      head_d            = head_q + CW'(1);
    end
    // Allocation follows the pop so a full-queue push may reuse the freed head slot.
    if (accept) begin
      if ((|match) && (!head_hit || !drain)) begin
        ctr_d[hit_slot] = step(ctr_q[hit_slot], bus.cm_taken_i);
        pc_d[hit_slot]  = bus.cm_pc_i;
        bhr_d[hit_slot] = bus.cm_bhr_i;
      end else begin
        ctr_d[tail_ptr]   = head_hit ? step(ctr_q[head_ptr], bus.cm_taken_i)
                                     : step(bus.cm_pht_i, bus.cm_taken_i);
        pc_d[tail_ptr]    = bus.cm_pc_i;
        bhr_d[tail_ptr]   = bus.cm_bhr_i;
        idx_d[tail_ptr]   = in_idx;
        valid_d[tail_ptr] = 1'b1;
        tail_d            = tail_q + CW'(1);
      end
      if (bus.cm_mispredict_i) begin
        prmiss_d       = 1'b1;
        prmiss_bhr_d   = bus.cm_bhr_i;
        prmiss_taken_d = bus.cm_taken_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      prmiss_q       <= 1'b0;
      prmiss_bhr_q   <= '0;
      prmiss_taken_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= '0;
        pc_q[i]  <= '0;
        bhr_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      valid_q        <= valid_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      prmiss_q       <= prmiss_d;
      prmiss_bhr_q   <= prmiss_bhr_d;
      prmiss_taken_q <= prmiss_taken_d;
      ctr_q          <= ctr_d;
      pc_q           <= pc_d;
      bhr_q          <= bhr_d;
      idx_q          <= idx_d;
    end
  end

  assign bus.cm_ready_o     = !full || drain || nonhead_hit;
  assign bus.wepht_o        = !empty;
  assign bus.fixpht_o       = ctr_q[head_ptr];
  assign bus.fixpc_o        = pc_q[head_ptr];
  assign bus.fixbhr_o       = bhr_q[head_ptr];
  assign bus.prmiss_o       = prmiss_q;
  assign bus.prmiss_bhr_o   = prmiss_bhr_q;
  assign bus.prmiss_taken_o = prmiss_taken_q;
  assign bus.count_o        = count;
endmodule

// File: tb/tb_gshare_pht_updater.sv
// Scenario bench for gshare_pht_updater; a negedge scoreboard models the pending
// write queue and repair pulse, and each scenario task adds its own direct checks.
module tb_gshare_pht_updater;
  localparam int PC_W = 32;
  localparam int BL   = 8;
  localparam int DEP  = 4;

  typedef struct {
    logic [BL-1:0]   idx;
    logic [1:0]      ctr;
    logic [PC_W-1:0] pc;
    logic [BL-1:0]   bhr;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ent_t          mq[$];
  logic          exp_prm = 1'b0;
  logic [BL-1:0] exp_prm_bhr = '0;
  logic          exp_prm_taken = 1'b0;

  gshare_pht_if #(.PC_W(PC_W), .BHR_LEN(BL), .DEPTH(DEP)) bus();

  gshare_pht_updater #(.PC_W(PC_W), .BHR_LEN(BL), .DEPTH(DEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic t);
    logic [2:0] w;
    w = t ? {1'b0, c} + 3'd1 : {1'b0, c} - 3'd1;
    if (t && c == 2'd3) return 2'd3;
    if (!t && c == 2'd0) return 2'd0;
    return w[1:0];
  endfunction

  // Reference queue model: front is the next write the PHT should see.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      exp_prm = 1'b0;
    end else begin
      logic          m_drain, m_ready, m_acc;
      int            j;
      logic [BL-1:0] idx;
      ent_t          e;
      n_cmp++;
      if (bus.prmiss_o !== exp_prm) begin
        n_err++; $display("[TB] FAIL sb_prmiss: got %0b expected %0b", bus.prmiss_o, exp_prm);
      end
      if (exp_prm) begin
        n_cmp++;
        if (bus.prmiss_bhr_o !== exp_prm_bhr || bus.prmiss_taken_o !== exp_prm_taken) begin
          n_err++; $display("[TB] FAIL sb_prmiss_data: got bhr %0h taken %0b expected bhr %0h taken %0b",
                            bus.prmiss_bhr_o, bus.prmiss_taken_o, exp_prm_bhr, exp_prm_taken);
        end
      end
      n_cmp++;
      if (bus.count_o !== 3'(mq.size()) || bus.wepht_o !== (mq.size() != 0)) begin
        n_err++; $display("[TB] FAIL sb_count: got count %0d wepht %0b expected count %0d",
                          bus.count_o, bus.wepht_o, mq.size());
      end
      m_drain = (mq.size() != 0) && bus.wr_ready_i;
      if (m_drain) begin
        n_cmp++;
        if (bus.fixpht_o !== mq[0].ctr || bus.fixpc_o !== mq[0].pc || bus.fixbhr_o !== mq[0].bhr) begin
          n_err++; $display("[TB] FAIL sb_write: got ctr %0d pc %0h bhr %0h expected ctr %0d pc %0h bhr %0h",
                            bus.fixpht_o, bus.fixpc_o, bus.fixbhr_o, mq[0].ctr, mq[0].pc, mq[0].bhr);
        end
      end
      idx = bus.cm_pc_i[9:2] ^ bus.cm_bhr_i;
      j = -1;
      for (int k = 0; k < mq.size(); k++) if (mq[k].idx == idx) j = k;
      m_ready = (mq.size() < DEP) || m_drain || (j > 0);
      n_cmp++;
      if (bus.cm_ready_o !== m_ready) begin
        n_err++; $display("[TB] FAIL sb_ready: got %0b expected %0b", bus.cm_ready_o, m_ready);
      end
      m_acc = bus.cm_valid_i && m_ready;
      exp_prm = m_acc && bus.cm_mispredict_i;
      if (exp_prm) begin
        exp_prm_bhr   = bus.cm_bhr_i;
        exp_prm_taken = bus.cm_taken_i;
      end
      if (m_acc) begin
        if (j >= 0 && (j != 0 || !m_drain)) begin
          e = mq[j];
          e.ctr = sat_step(e.ctr, bus.cm_taken_i);
          e.pc  = bus.cm_pc_i;
          e.bhr = bus.cm_bhr_i;
          mq[j] = e;
        end else begin
          e.idx = idx;
          e.ctr = (j == 0) ? sat_step(mq[0].ctr, bus.cm_taken_i) : sat_step(bus.cm_pht_i, bus.cm_taken_i);
          e.pc  = bus.cm_pc_i;
          e.bhr = bus.cm_bhr_i;
          mq.push_back(e);
        end
      end
      if (m_drain) void'(mq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [7:0] bhr,
                       input logic [1:0] pht, input logic t, input logic mp);
    bus.cm_valid_i      = v;
    bus.cm_pc_i         = pc;
    bus.cm_bhr_i        = bhr;
    bus.cm_pht_i        = pht;
    bus.cm_taken_i      = t;
    bus.cm_mispredict_i = mp;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    bus.wr_ready_i = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.cm_ready_o !== 1'b1 || bus.wepht_o !== 1'b0 || bus.count_o !== 3'd0 ||
        bus.fixpht_o !== 2'd0 || bus.fixpc_o !== 32'h0 || bus.fixbhr_o !== 8'h0 ||
        bus.prmiss_o !== 1'b0 || bus.prmiss_bhr_o !== 8'h0 || bus.prmiss_taken_o !== 1'b0) begin
      n_err++; $display("[TB] FAIL reset_state: got ready %0b wepht %0b count %0d fixpht %0d prmiss %0b expected 1 0 0 0 0",
                        bus.cm_ready_o, bus.wepht_o, bus.count_o, bus.fixpht_o, bus.prmiss_o);
    end
  endtask

  task automatic test_basic();
    bus.wr_ready_i = 1'b1;
    drive(1'b1, 32'h8000_0010, 8'h00, 2'd1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.wepht_o !== 1'b1 || bus.fixpht_o !== 2'd2 || bus.fixpc_o !== 32'h8000_0010 || bus.fixbhr_o !== 8'h00) begin
      n_err++; $display("[TB] FAIL basic_write: got wepht %0b ctr %0d pc %0h bhr %0h expected 1 2 80000010 0",
                        bus.wepht_o, bus.fixpht_o, bus.fixpc_o, bus.fixbhr_o);
    end
    tick();
    n_cmp++;
    if (bus.count_o !== 3'd0) begin
      n_err++; $display("[TB] FAIL basic_count: got %0d expected 0", bus.count_o);
    end
  endtask

  task automatic test_saturation();
    bus.wr_ready_i = 1'b1;
    drive(1'b1, 32'h0000_0040, 8'h03, 2'd3, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.fixpht_o !== 2'd3) begin
      n_err++; $display("[TB] FAIL sat_high: got %0d expected 3", bus.fixpht_o);
    end
    tick();
    drive(1'b1, 32'h0000_0080, 8'h07, 2'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.fixpht_o !== 2'd0 || bus.wepht_o !== 1'b1) begin
      n_err++; $display("[TB] FAIL sat_low: got ctr %0d wepht %0b expected 0 1", bus.fixpht_o, bus.wepht_o);
    end
    tick();
  endtask

  task automatic test_coalesce();
    bus.wr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_0120, 8'h11, 2'd0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.count_o !== 3'd1 || bus.fixpht_o !== 2'd3) begin
      n_err++; $display("[TB] FAIL coalesce: got count %0d ctr %0d expected 1 3", bus.count_o, bus.fixpht_o);
    end
    bus.wr_ready_i = 1'b1;
    tick();
    n_cmp++;
    if (bus.count_o !== 3'd0) begin
      n_err++; $display("[TB] FAIL coalesce_drain: got %0d expected 0", bus.count_o);
    end
  endtask

  task automatic test_full();
    bus.wr_ready_i = 1'b0;
    for (int i = 0; i < DEP; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 8'h00, 2'd1, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 32'h110, 8'h00, 2'd1, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (bus.cm_ready_o !== 1'b0 || bus.count_o !== 3'd4) begin
      n_err++; $display("[TB] FAIL full_block: got ready %0b count %0d expected 0 4", bus.cm_ready_o, bus.count_o);
    end
    drive(1'b1, 32'h108, 8'h00, 2'd0, 1'b1, 1'b0);
    #1;
    n_cmp++;
    if (bus.cm_ready_o !== 1'b1) begin
      n_err++; $display("[TB] FAIL full_hit_ready: got %0b expected 1", bus.cm_ready_o);
    end
    tick();
    bus.wr_ready_i = 1'b1;
    drive(1'b1, 32'h110, 8'h00, 2'd2, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (bus.cm_ready_o !== 1'b1) begin
      n_err++; $display("[TB] FAIL full_drain_ready: got %0b expected 1", bus.cm_ready_o);
    end
    tick();
    drive(1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.count_o !== 3'd4 || bus.fixpc_o !== 32'h104) begin
      n_err++; $display("[TB] FAIL full_pushpop: got count %0d head pc %0h expected 4 104", bus.count_o, bus.fixpc_o);
    end
    repeat (5) tick();
    n_cmp++;
    if (bus.count_o !== 3'd0) begin
      n_err++; $display("[TB] FAIL full_drain: got %0d expected 0", bus.count_o);
    end
  endtask

  task automatic test_mispredict();
    bus.wr_ready_i = 1'b1;
    drive(1'b1, 32'h400, 8'hA5, 2'd2, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h440, 8'h5A, 2'd2, 1'b0, 1'b1);
    n_cmp++;
    if (bus.prmiss_o !== 1'b1 || bus.prmiss_bhr_o !== 8'hA5 || bus.prmiss_taken_o !== 1'b1) begin
      n_err++; $display("[TB] FAIL misp_first: got %0b %0h %0b expected 1 a5 1",
                        bus.prmiss_o, bus.prmiss_bhr_o, bus.prmiss_taken_o);
    end
    tick();
    drive(1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.prmiss_o !== 1'b1 || bus.prmiss_bhr_o !== 8'h5A || bus.prmiss_taken_o !== 1'b0) begin
      n_err++; $display("[TB] FAIL misp_second: got %0b %0h %0b expected 1 5a 0",
                        bus.prmiss_o, bus.prmiss_bhr_o, bus.prmiss_taken_o);
    end
    tick();
    n_cmp++;
    if (bus.prmiss_o !== 1'b0) begin
      n_err++; $display("[TB] FAIL misp_pulse_end: got %0b expected 0", bus.prmiss_o);
    end
  endtask

  task automatic test_reset_midop();
    bus.wr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 8'h01, 2'd1, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.count_o !== 3'd3) begin
      n_err++; $display("[TB] FAIL midop_fill: got %0d expected 3", bus.count_o);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bus.wepht_o !== 1'b0 || bus.count_o !== 3'd0) begin
      n_err++; $display("[TB] FAIL midop_reset: got wepht %0b count %0d expected 0 0", bus.wepht_o, bus.count_o);
    end
    rst = 1'b0;
    bus.wr_ready_i = 1'b1;
    repeat (4) begin
      tick();
      n_cmp++;
      if (bus.wepht_o !== 1'b0) begin
        n_err++; $display("[TB] FAIL midop_no_write: got %0b expected 0", bus.wepht_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 32'h200 + 32'(4 * $urandom_range(0, 5)),
            8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0));
      bus.wr_ready_i = 1'($urandom_range(0, 2) == 0);
      tick();
    end
    drive(1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 1'b0);
    bus.wr_ready_i = 1'b1;
    repeat (DEP + 2) tick();
    n_cmp++;
    if (mq.size() != 0 || bus.count_o !== 3'd0) begin
      n_err++; $display("[TB] FAIL b2b_drain: got count %0d model %0d expected 0", bus.count_o, mq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_coalesce();
    test_full();
    test_mispredict();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
